// File: rtl/wiscv_mem_pkg.sv
// Shared types and constants for the wiscv data-memory controller.
package wiscv_mem_pkg;

    localparam int BANK_AW_DEF = 13;
    localparam int NUM_BANKS   = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        RESP = 2'b11
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e s);
        case (s)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/wiscv_mem_if.sv
// Request/response bundle between the core memory stage and the controller.
interface wiscv_mem_if
    import wiscv_mem_pkg::*;
#(
    parameter int BANK_AW = BANK_AW_DEF
) ();

    // Handshake: a request transfers on a rising clk edge where req_valid and
    // req_ready are both high; the requester holds every req_* field stable
    // until then. rsp_valid is a single-cycle pulse with no back-pressure, and
    // rsp_rdata/rsp_err are meaningful only while it is high.
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [BANK_AW+1:0] req_addr;
    logic [31:0]        req_wdata;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/wiscv_mem_lane_steer.sv
// Combinational byte-lane steering: maps an access onto bank lanes per phase
// and reassembles captured bank bytes into an extended load result.
module wiscv_mem_lane_steer
    import wiscv_mem_pkg::*;
#(
    parameter int BANK_AW = BANK_AW_DEF
) (
    input  logic [BANK_AW+1:0]        i_addr,
    input  size_e                     i_size,
    input  logic                      i_unsigned,
    input  logic [31:0]               i_wdata,
    input  logic [NUM_BANKS-1:0][7:0] i_cap,
    output logic [NUM_BANKS-1:0]      o_mask0,
    output logic [NUM_BANKS-1:0]      o_mask1,
    output logic [BANK_AW-1:0]        o_row0,
    output logic [BANK_AW-1:0]        o_row1,
    output logic [NUM_BANKS-1:0][7:0] o_wbyte,
    output logic [31:0]               o_rdata
);

    logic [2:0]                w_nbytes;
    logic [NUM_BANKS-1:0][1:0] w_k;
    logic [NUM_BANKS-1:0][2:0] w_pos;
    logic [31:0]               w_asm;

    assign w_nbytes = size_bytes(i_size);
    assign o_row0   = i_addr[BANK_AW+1:2];
    assign o_row1   = o_row0 + {{(BANK_AW-1){1'b0}}, 1'b1};

    // Each bank serves at most one byte of an access; a carry out of the
    // lane offset means that byte lives in the next row.
    always_comb begin
        o_mask0 = '0;
        o_mask1 = '0;
        o_wbyte = '0;
        w_k     = '0;
        w_pos   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_k[b]   = 2'(b) - i_addr[1:0];
            w_pos[b] = {1'b0, i_addr[1:0]} + {1'b0, w_k[b]};
            if ({1'b0, w_k[b]} < w_nbytes) begin
                if (w_pos[b][2]) begin
                    o_mask1[b] = 1'b1;
                end else begin
                    o_mask0[b] = 1'b1;
                end
                o_wbyte[b] = i_wdata[8*w_k[b] +: 8];
            end
        end
    end

    always_comb begin
        w_asm = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            w_asm[8*k +: 8] = i_cap[i_addr[1:0] + 2'(k)];
        end
        o_rdata = '0;
        case (i_size)
            SZ_B:    o_rdata = {{24{~i_unsigned & w_asm[7]}}, w_asm[7:0]};
            SZ_H:    o_rdata = {{16{~i_unsigned & w_asm[15]}}, w_asm[15:0]};
            SZ_W:    o_rdata = w_asm;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/wiscv_mem_ctrl.sv
// Data-memory initiator: turns one load/store per handshake into one or two
// registered bank phases and a single-cycle response.
module wiscv_mem_ctrl
    import wiscv_mem_pkg::*;
#(
    parameter int BANK_AW = BANK_AW_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    wiscv_mem_if.slave                        mem,
    output logic [NUM_BANKS-1:0][BANK_AW-1:0] bank_addr,
    output logic [NUM_BANKS-1:0]              bank_re,
    output logic [NUM_BANKS-1:0]              bank_we,
    output logic [NUM_BANKS-1:0][7:0]         bank_wdata,
    input  logic [NUM_BANKS-1:0][7:0]         bank_rdata,
    output state_e                            o_dbg_state
);

    state_e                            r_state;
    state_e                            w_next;
    logic                              r_we;
    size_e                             r_size;
    logic                              r_uns;
    logic [BANK_AW+1:0]                r_addr;
    logic [31:0]                       r_wdata;
    logic [NUM_BANKS-1:0][7:0]         r_cap;
    logic [NUM_BANKS-1:0][BANK_AW-1:0] r_bank_addr;
    logic [NUM_BANKS-1:0]              r_bank_re;
    logic [NUM_BANKS-1:0]              r_bank_we;
    logic [NUM_BANKS-1:0][7:0]         r_bank_wdata;

    logic                              w_idle;
    size_e                             w_in_size;
    logic [BANK_AW+1:0]                w_s_addr;
    size_e                             w_s_size;
    logic                              w_s_uns;
    logic [31:0]                       w_s_wdata;
    logic [NUM_BANKS-1:0]              w_mask0;
    logic [NUM_BANKS-1:0]              w_mask1;
    logic [BANK_AW-1:0]                w_row0;
    logic [BANK_AW-1:0]                w_row1;
    logic [NUM_BANKS-1:0][7:0]         w_wbyte;
    logic [31:0]                       w_rdata;
    logic [NUM_BANKS-1:0]              w_lanes;
    logic [BANK_AW-1:0]                w_row;
    logic                              w_lane_we;
    logic [NUM_BANKS-1:0][BANK_AW-1:0] w_nx_addr;
    logic [NUM_BANKS-1:0]              w_nx_re;
    logic [NUM_BANKS-1:0]              w_nx_we;
    logic [NUM_BANKS-1:0][7:0]         w_nx_wdata;

    assign w_idle    = (r_state == IDLE);
    assign w_in_size = size_e'(mem.req_size);

    // In IDLE the steering looks at the live request so phase 0 can be
    // registered on the accepting edge; afterwards it sees the held copy.
    assign w_s_addr  = w_idle ? mem.req_addr     : r_addr;
    assign w_s_size  = w_idle ? w_in_size        : r_size;
    assign w_s_uns   = w_idle ? mem.req_unsigned : r_uns;
    assign w_s_wdata = w_idle ? mem.req_wdata    : r_wdata;

    wiscv_mem_lane_steer #(.BANK_AW(BANK_AW)) u_steer (
        .i_addr     (w_s_addr),
        .i_size     (w_s_size),
        .i_unsigned (w_s_uns),
        .i_wdata    (w_s_wdata),
        .i_cap      (r_cap),
        .o_mask0    (w_mask0),
        .o_mask1    (w_mask1),
        .o_row0     (w_row0),
        .o_row1     (w_row1),
        .o_wbyte    (w_wbyte),
        .o_rdata    (w_rdata)
    );

    always_comb begin
        w_next     = r_state;
        w_lanes    = '0;
        w_row      = '0;
        w_lane_we  = 1'b0;
        w_nx_addr  = '0;
        w_nx_re    = '0;
        w_nx_we    = '0;
        w_nx_wdata = '0;
        case (r_state)
            IDLE: begin
                if (mem.req_valid) begin
                    if (w_in_size == SZ_BAD) begin
                        w_next = RESP;
                    end else begin
                        w_next    = ACC0;
                        w_lanes   = w_mask0;
                        w_row     = w_row0;
                        w_lane_we = mem.req_we;
                    end
                end
            end
            ACC0: begin
                if (|w_mask1) begin
                    w_next    = ACC1;
                    w_lanes   = w_mask1;
                    w_row     = w_row1;
                    w_lane_we = r_we;
                end else begin
                    w_next = RESP;
                end
            end
            ACC1:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_lanes[b]) begin
                w_nx_addr[b] = w_row;
                w_nx_re[b]   = ~w_lane_we;
                w_nx_we[b]   = w_lane_we;
                w_nx_wdata[b] = w_lane_we ? w_wbyte[b] : 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= SZ_B;
            r_uns        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cap        <= '0;
            r_bank_addr  <= '0;
            r_bank_re    <= '0;
            r_bank_we    <= '0;
            r_bank_wdata <= '0;
        end else begin
            r_state      <= w_next;
            r_bank_addr  <= w_nx_addr;
            r_bank_re    <= w_nx_re;
            r_bank_we    <= w_nx_we;
            r_bank_wdata <= w_nx_wdata;
            if (w_idle && mem.req_valid) begin
                r_we    <= mem.req_we;
                r_size  <= w_in_size;
                r_uns   <= mem.req_unsigned;
                r_addr  <= mem.req_addr;
                r_wdata <= mem.req_wdata;
            end
            // Banks update bank_rdata on the negedge inside the ACC cycle.
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_bank_re[b]) begin
                    r_cap[b] <= bank_rdata[b];
                end
            end
        end
    end

    assign mem.req_ready = w_idle;
    assign mem.rsp_valid = (r_state == RESP);
    assign mem.rsp_err   = (r_state == RESP) && (r_size == SZ_BAD);
    assign mem.rsp_rdata = ((r_state == RESP) && !r_we) ? w_rdata : 32'h0;

    assign bank_addr   = r_bank_addr;
    assign bank_re     = r_bank_re;
    assign bank_we     = r_bank_we;
    assign bank_wdata  = r_bank_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wiscv_mem_ctrl.sv
// Bench for wiscv_mem_ctrl: byte-addressed reference memory plus a per-cycle
// expected-output queue, directed boundary cases and randomized traffic.
`timescale 1ns/1ps
module tb_wiscv_mem_ctrl;
  import wiscv_mem_pkg::*;

  localparam int AW        = 13;
  localparam int MEM_BYTES = 1 << (AW + 2);

  typedef struct packed {
    logic                 ready;
    logic                 rsp_valid;
    logic                 err;
    logic [31:0]          rdata;
    logic [3:0]           re;
    logic [3:0]           we;
    logic [3:0][AW-1:0]   addr;
    logic [3:0][7:0]      wdata;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wiscv_mem_if #(.BANK_AW(AW)) mif ();
  logic [3:0][AW-1:0] bank_addr;
  logic [3:0]         bank_re;
  logic [3:0]         bank_we;
  logic [3:0][7:0]    bank_wdata;
  logic [3:0][7:0]    bank_rdata;
  state_e             dbg_state;

  wiscv_mem_ctrl #(.BANK_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif.slave),
    .bank_addr   (bank_addr),
    .bank_re     (bank_re),
    .bank_we     (bank_we),
    .bank_wdata  (bank_wdata),
    .bank_rdata  (bank_rdata),
    .o_dbg_state (dbg_state)
  );

  function automatic logic [7:0] init_byte(input logic [14:0] a);
    logic [14:0] t;
    case (a)
      15'h0010: return 8'h11;
      15'h0011: return 8'h22;
      15'h0012: return 8'h33;
      15'h0013: return 8'h44;
      15'h0005: return 8'h80;
      15'h7FFE: return 8'hA1;
      15'h7FFF: return 8'hB2;
      15'h0000: return 8'hC3;
      15'h0001: return 8'hD4;
      default: begin
        t = a * 15'd7 + (a >> 5) + 15'h5A;
        return t[7:0] ^ t[14:7];
      end
    endcase
  endfunction

  // ---------------- bank environment ----------------
  logic [7:0] bank_mem [4][1 << AW];
  bit         bm_init = 1'b0;

  always @(negedge clk) begin
    if (!bm_init) begin
      for (int r = 0; r < (1 << AW); r++) begin
        for (int b = 0; b < 4; b++) begin
          bank_mem[b][r] = init_byte(15'(r * 4 + b));
        end
      end
      bank_rdata <= '0;
      bm_init = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      if (bank_we[b]) bank_mem[b][bank_addr[b]] = bank_wdata[b];
      if (bank_re[b]) bank_rdata[b] <= bank_mem[b][bank_addr[b]];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]       ref_mem [MEM_BYTES];
  logic [OBS_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               acc_cyc  = 0;
  int               last_rsp_cyc = -1;
  logic [31:0]      last_rdata = '0;
  logic             last_err   = 1'b0;

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Expected trace for one request, starting with its acceptance cycle.
  task automatic push_expect(input logic we, input logic [1:0] size, input logic uns,
                             input logic [14:0] a, input logic [31:0] wd, input bit abort);
    obs_t        ph [2];
    obs_t        rs;
    bit          has1;
    int          n;
    int          p;
    logic [14:0] ba;
    logic [31:0] val;
    exp_q.push_back(idle_obs());
    ph[0] = '0;
    ph[1] = '0;
    rs = '0;
    rs.rsp_valid = 1'b1;
    if (size == 2'b11) begin
      rs.err = 1'b1;
      exp_q.push_back(rs);
      return;
    end
    n = 1 << size;
    val = '0;
    has1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      ba = a + 15'(k);
      p = (ba[14:2] == a[14:2]) ? 0 : 1;
      if (p == 1) has1 = 1'b1;
      ph[p].addr[ba[1:0]] = ba[14:2];
      if (we) begin
        ph[p].we[ba[1:0]]    = 1'b1;
        ph[p].wdata[ba[1:0]] = wd[8*k +: 8];
        if (!abort || p == 0) ref_mem[ba] = wd[8*k +: 8];
      end else begin
        ph[p].re[ba[1:0]] = 1'b1;
        val[8*k +: 8] = ref_mem[ba];
      end
    end
    if (!we && !uns) begin
      if (n == 1 && val[7])  val[31:8]  = '1;
      if (n == 2 && val[15]) val[31:16] = '1;
    end
    if (!we) rs.rdata = val;
    exp_q.push_back(ph[0]);
    if (has1 && !abort) exp_q.push_back(ph[1]);
    if (!abort) exp_q.push_back(rs);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    obs_t act;
    obs_t e;
    act.ready     = mif.req_ready;
    act.rsp_valid = mif.rsp_valid;
    act.err       = mif.rsp_err;
    act.rdata     = mif.rsp_rdata;
    act.re        = bank_re;
    act.we        = bank_we;
    act.addr      = bank_addr;
    act.wdata     = bank_wdata;
    if (exp_q.size() > 0) e = obs_t'(exp_q.pop_front());
    else                  e = idle_obs();
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL cycle_%0d: got rdy=%b rv=%b err=%b rdata=%h re=%b we=%b addr=%h wdata=%h, expected rdy=%b rv=%b err=%b rdata=%h re=%b we=%b addr=%h wdata=%h",
               cyc, act.ready, act.rsp_valid, act.err, act.rdata, act.re, act.we, act.addr, act.wdata,
               e.ready, e.rsp_valid, e.err, e.rdata, e.re, e.we, e.addr, e.wdata);
    end
    if (act.rsp_valid) begin
      last_rdata   = act.rdata;
      last_err     = act.err;
      last_rsp_cyc = cyc;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive_noise();
    mif.req_valid    = 1'b1;
    mif.req_we       = 1'($urandom_range(0, 1));
    mif.req_size     = 2'($urandom_range(0, 3));
    mif.req_unsigned = 1'($urandom_range(0, 1));
    mif.req_addr     = 15'($urandom);
    mif.req_wdata    = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [14:0] a, input logic [31:0] wd, input bit abort);
    int guard;
    mif.req_valid    = 1'b1;
    mif.req_we       = we;
    mif.req_size     = size;
    mif.req_unsigned = uns;
    mif.req_addr     = a;
    mif.req_wdata    = wd;
    push_expect(we, size, uns, a, wd, abort);
    acc_cyc = cyc;
    step();
    drive_noise();
    if (abort) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      mif.req_valid = 1'b0;
      return;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 8) begin
      step();
      drive_noise();
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d expected cycles left, required 0", exp_q.size());
      exp_q.delete();
    end
    mif.req_valid = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    int          mism;
    logic [1:0]  sz;
    logic [14:0] ra;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(15'(i));
    mif.req_valid    = 1'b0;
    mif.req_we       = 1'b0;
    mif.req_size     = 2'b00;
    mif.req_unsigned = 1'b0;
    mif.req_addr     = '0;
    mif.req_wdata    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(mif.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(mif.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", mif.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(mif.rsp_err), 32'd0);
    chk("reset_bank_strobes", {24'd0, bank_re, bank_we}, 32'd0);
    chk("reset_bank_data", 32'(|{bank_addr, bank_wdata}), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    step();
    step();

    do_req(1'b0, 2'b10, 1'b0, 15'h0010, 32'h0, 1'b0);
    chk("lw_0010_data", last_rdata, 32'h44332211);
    chk("lw_0010_latency", 32'(last_rsp_cyc - acc_cyc), 32'd2);

    do_req(1'b1, 2'b01, 1'b0, 15'h0003, 32'h0000BEEF, 1'b0);
    chk("sh_0003_bank3_row0", 32'(bank_mem[3][0]), 32'h000000EF);
    chk("sh_0003_bank0_row1", 32'(bank_mem[0][1]), 32'h000000BE);
    chk("sh_0003_latency", 32'(last_rsp_cyc - acc_cyc), 32'd3);

    do_req(1'b0, 2'b00, 1'b0, 15'h0005, 32'h0, 1'b0);
    chk("lb_signed", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 15'h0005, 32'h0, 1'b0);
    chk("lb_unsigned", last_rdata, 32'h00000080);

    do_req(1'b0, 2'b10, 1'b1, 15'h7FFE, 32'h0, 1'b0);
    chk("lw_wrap_data", last_rdata, 32'hD4C3B2A1);
    chk("lw_wrap_latency", 32'(last_rsp_cyc - acc_cyc), 32'd3);
    do_req(1'b0, 2'b01, 1'b0, 15'h7FFF, 32'h0, 1'b0);
    chk("lh_wrap_signed", last_rdata, 32'hFFFFC3B2);

    do_req(1'b1, 2'b11, 1'b0, 15'h0100, 32'hFFFFFFFF, 1'b0);
    chk("bad_size_err", 32'(last_err), 32'd1);
    chk("bad_size_rdata", last_rdata, 32'd0);
    chk("bad_size_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 15'h0021, 32'hCAFEF00D, 1'b1);
    chk("abort_ready", 32'(mif.req_ready), 32'd1);
    step();
    step();
    chk("abort_b1", 32'(bank_mem[1][8]), 32'h0000000D);
    chk("abort_b2", 32'(bank_mem[2][8]), 32'h000000F0);
    chk("abort_b3", 32'(bank_mem[3][8]), 32'h000000FE);
    chk("abort_no_phase1", 32'(bank_mem[0][9]), 32'(init_byte(15'h0024)));
    chk("abort_no_rsp", 32'(last_rsp_cyc < acc_cyc), 32'd1);

    mif.req_valid = 1'b1;
    mif.req_we    = 1'b1;
    mif.req_size  = 2'b10;
    mif.req_addr  = 15'h0040;
    mif.req_wdata = 32'h12345678;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mif.req_valid = 1'b0;
    step();
    step();
    chk("rst_dominates_valid", 32'(bank_mem[0][16]), 32'(init_byte(15'h0040)));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) sz = 2'b11;
      else                           sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) ra = 15'h7FFC + 15'($urandom_range(0, 5));
      else                           ra = 15'($urandom);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    mism = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (bank_mem[i % 4][i / 4] !== ref_mem[i]) mism++;
    end
    chk("final_memory_mismatches", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
